// File: rtl/ram_port_pkg.sv
// Shared types and helpers for the ram_port memory stage.
package ram_port_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  // Even parity bit: makes the XOR of data plus parity bit equal zero.
  // Callers zero-extend; leading zeros do not change the result.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_port_array.sv
// Byte-addressed storage: synchronous write, registered read, out-of-range
// writes dropped and out-of-range reads returning zero.
module ram_port_array #(
  parameter int ADDR_W = 15,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign in_range = ({1'b0, addr_i} < DEPTH_L);
  assign idx      = addr_i[IDX_W-1:0];

  // NOTE: storage has no reset so it maps onto RAM macros and keeps its
  // contents across rst_n; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i && in_range) mem_q[idx] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= in_range ? mem_q[idx] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_port.sv
// Memory-side port: latches one request, waits WAIT_CYCLES, accesses the
// array and pulses ready. Define RAM_PORT_PARITY_EN to store a parity bit.
module ram_port
  import ram_port_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 32768,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              parity_err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef RAM_PORT_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              mem_we, mem_re;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins when both strobes are high.
        if (wr_req || rd_req) begin
          addr_d  = addr;
          wdata_d = wr_data;
          is_wr_d = wr_req;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we  = is_wr_q;
          mem_re  = !is_wr_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_PORT_PARITY_EN
  assign mem_wdata  = {even_parity(64'(wdata_q)), wdata_q};
  assign parity_err = ready && !is_wr_q &&
                      (mem_rdata[DATA_W] != even_parity(64'(mem_rdata[DATA_W-1:0])));
`else
  assign mem_wdata  = wdata_q;
  assign parity_err = 1'b0;
`endif

  ram_port_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign rd_data = mem_rdata[DATA_W-1:0];
  assign ready   = (state_q == DONE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port.sv
// Scoreboard bench for ram_port: a byte-array model predicts each completion,
// a monitor checks every ready pulse against the queued prediction.
module tb_ram_port;

  localparam int W     = 1;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] addr = '0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        ready, busy, parity_err;

  logic [14:0] addr0 = '0;
  logic        rd_req0 = 1'b0, wr_req0 = 1'b0;
  logic [7:0]  wr_data0 = '0;
  logic [7:0]  rd_data0;
  logic        ready0, busy0, parity_err0;

  ram_port #(.ADDR_W(15), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .busy(busy),
    .parity_err(parity_err)
  );

  ram_port #(.ADDR_W(15), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .rd_req(rd_req0), .wr_req(wr_req0),
    .wr_data(wr_data0), .rd_data(rd_data0), .ready(ready0), .busy(busy0),
    .parity_err(parity_err0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         rdy_cyc;
    bit         perr;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] mem_m [int];
  int         written[$];
  logic [7:0] last_rd = 8'h00;
  bit         next_perr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the port must report at completion.
  task automatic predict(input bit wr, input logic [14:0] a, input logic [7:0] d, input int issue);
    exp_t e;
    e.rdy_cyc = issue + W + 2;
    e.perr    = next_perr;
    next_perr = 1'b0;
    if (wr) begin
      if (int'(a) < DEPTH) begin
        mem_m[int'(a)] = d;
        written.push_back(int'(a));
      end
      e.data = last_rd;
    end else begin
      e.data  = (int'(a) < DEPTH) ? mem_m[int'(a)] : 8'h00;
      last_rd = e.data;
    end
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: ready=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
        check("rd_data", 32'(rd_data), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end
  end

  // Present one request and hold it until ready. Returns at the negedge of
  // the ready cycle. from_ready: called from that negedge (streaming).
  task automatic txn(input bit wr, input bit rd, input logic [14:0] a, input logic [7:0] d,
                     input bit chaos, input bit from_ready);
    int issue;
    bit busy_ok;
    bit done;
    wr_req  = wr;
    rd_req  = rd;
    addr    = a;
    wr_data = d;
    issue   = from_ready ? cyc + 1 : cyc;
    predict(wr, a, d, issue);
    busy_ok = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < W + 10 && !done; i++) begin
      @(negedge clk);
      if (busy !== (cyc > issue)) busy_ok = 1'b0;
      if (ready) begin
        done = 1'b1;
      end else if (busy && chaos) begin
        wr_req  = 1'($urandom);
        rd_req  = 1'($urandom);
        addr    = 15'($urandom);
        wr_data = 8'($urandom);
      end
    end
    check("busy_track", 32'(busy_ok), 32'(1));
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: no ready within %0d cycles of issue %0d", W + 10, issue);
      void'(sb_q.pop_back());
      wr_req = 1'b0;
      rd_req = 1'b0;
    end
  endtask

  task automatic drop(input int gap);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0(output int at);
    at = -1;
    for (int i = 0; i < 10 && at < 0; i++) begin
      @(negedge clk);
      if (ready0) at = cyc;
    end
  endtask

  initial begin
    int at;
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_parity_err", 32'(parity_err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write, read, hold
    txn(1, 0, 15'h0010, 8'hA5, 0, 0);
    drop(1);
    txn(0, 1, 15'h0010, 8'h00, 0, 0);
    drop(3);
    check("rd_hold", 32'(rd_data), 32'(last_rd));

    // Both strobes high: write wins; toggling while busy has no effect
    txn(1, 1, 15'h0020, 8'h3C, 1, 0);
    drop(2);
    txn(0, 1, 15'h0020, 8'h00, 1, 0);
    drop(1);

    // Range boundaries
    txn(1, 0, 15'h0400, 8'hFF, 0, 0);
    drop(1);
    txn(0, 1, 15'h0400, 8'h00, 0, 0);
    txn(1, 0, 15'h0000, 8'h12, 0, 1);
    txn(1, 0, 15'h03FF, 8'hED, 0, 1);
    txn(0, 1, 15'h0000, 8'h00, 0, 1);
    txn(0, 1, 15'h03FF, 8'h00, 0, 1);
    drop(1);

    // Reset during ACCESS of a write discards it
    txn(1, 0, 15'h0005, 8'h11, 0, 0);
    drop(2);
    wr_req  = 1'b1;
    addr    = 15'h0005;
    wr_data = 8'h77;
    @(posedge clk);
    #1;
    check("busy_in_access", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_rd_data", 32'(rd_data), 32'(0));
    last_rd = 8'h00;
    wr_req  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1, 15'h0005, 8'h00, 0, 0);
    drop(1);

    // Random traffic, mixing gaps and streaming
    for (int n = 0; n < 80; n++) begin
      bit          wr, rd, stream;
      logic [14:0] a;
      k  = int'($urandom_range(0, 9));
      wr = (k < 4) || (k == 9);
      rd = !wr || (k == 9);
      if (wr) begin
        a = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(DEPTH, 32767))
                                         : 15'($urandom_range(0, DEPTH - 1));
      end else if (written.size() == 0 || $urandom_range(0, 7) == 0) begin
        a = 15'($urandom_range(DEPTH, 32767));
      end else begin
        a = 15'(written[$urandom_range(0, written.size() - 1)]);
      end
      stream = (n > 0) && ($urandom_range(0, 2) == 0);
      if (!stream && n > 0) drop(int'($urandom_range(1, 3)));
      txn(wr, rd, a, 8'($urandom), 1'($urandom), stream);
    end
    drop(2);

`ifdef RAM_PORT_PARITY_EN
    txn(1, 0, 15'h0001, 8'h5E, 0, 0);
    drop(1);
    dut.u_array.mem_q[1][0] = ~dut.u_array.mem_q[1][0];
    mem_m[1] = mem_m[1] ^ 8'h01;
    next_perr = 1'b1;
    txn(0, 1, 15'h0001, 8'h00, 0, 0);
    drop(1);
    txn(0, 1, 15'h0010, 8'h00, 0, 0);
    drop(1);
`endif

    // WAIT_CYCLES = 0 instance: ready two cycles after the request
    wr_req0  = 1'b1;
    addr0    = 15'h0003;
    wr_data0 = 8'h5A;
    k = cyc;
    wait_ready0(at);
    check("w0_write_latency", 32'(at), 32'(k + 2));
    wr_req0 = 1'b0;
    @(posedge clk);
    #1;
    rd_req0 = 1'b1;
    k = cyc;
    wait_ready0(at);
    check("w0_read_latency", 32'(at), 32'(k + 2));
    check("w0_rd_data", 32'(rd_data0), 32'(8'h5A));
    rd_req0 = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
